// File: rtl/sha256_pkg.sv
// SHA-256 constants, round helper functions and shared types for the streaming compression core.
// Pure declarations: no logic, no latency, no flow control.
package sha256_pkg;

    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_FINAL, ST_OUT} state_e;

    // Field a sits in the top word so a work_t lines up with H0..H7 of a digest.
    typedef struct packed {
        logic [31:0] a, b, c, d, e, f, g, h;
    } work_t;

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [31:0] big_s0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_s1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] sml_s0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sml_s1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    function automatic work_t add_words(input work_t x, input work_t y);
        work_t r;
        for (int i = 0; i < 8; i++) begin
            r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
        end
        return r;
    endfunction

endpackage

// File: rtl/sha256_stream_core_if.sv
// Block-in / digest-out handshake bundle; slave is the hashing core, master is the block source and digest sink.
// Both directions are valid/ready; the core holds dig_valid and dig until dig_ready.
interface sha256_stream_core_if;
    logic         blk_valid;
    logic         blk_ready;
    logic         blk_first;
    logic         blk_last;
    logic [511:0] blk_data;
    logic         dig_valid;
    logic         dig_ready;
    logic [255:0] dig;
    logic         busy;

    modport master (
        output blk_valid, blk_first, blk_last, blk_data, dig_ready,
        input  blk_ready, dig_valid, dig, busy
    );

    modport slave (
        input  blk_valid, blk_first, blk_last, blk_data, dig_ready,
        output blk_ready, dig_valid, dig, busy
    );
endinterface

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round; chained to form several rounds per clock.
// No latency, no flow control.
module sha256_round
    import sha256_pkg::*;
(
    input  work_t       s_i,
    input  logic [31:0] k_i,
    input  logic [31:0] w_i,
    output work_t       s_o
);
    logic [31:0] t1;
    logic [31:0] t2;

    assign t1 = s_i.h + big_s1(s_i.e) + ch(s_i.e, s_i.f, s_i.g) + k_i + w_i;
    assign t2 = big_s0(s_i.a) + maj(s_i.a, s_i.b, s_i.c);

    assign s_o.a = t1 + t2;
    assign s_o.b = s_i.a;
    assign s_o.c = s_i.b;
    assign s_o.d = s_i.c;
    assign s_o.e = s_i.d + t1;
    assign s_o.f = s_i.e;
    assign s_o.g = s_i.f;
    assign s_o.h = s_i.g;
endmodule

// File: rtl/sha256_stream_core.sv
// Multi-block chained SHA-256 engine, ROUNDS_PER_CYCLE rounds per clock; digest 64/U+2 cycles after accept.
// One block in flight, no buffering; digest held until dig_ready. SHA256_DOUBLE_EN adds a second hash pass.
module sha256_stream_core
    import sha256_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input logic                 clk,
    input logic                 rst,
    sha256_stream_core_if.slave bus
);
    localparam int         U        = ROUNDS_PER_CYCLE;
    localparam logic [5:0] RND_LAST = 6'(64 - U);

    if (!(U == 1 || U == 2 || U == 4 || U == 8)) begin : g_bad_u
        $error("sha256_stream_core: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    state_e       state_q, state_d;
    work_t        h_q, h_d;
    work_t        s_q, s_d;
    logic [31:0]  w_q [0:15];
    logic [31:0]  w_d [0:15];
    logic [5:0]   rnd_q, rnd_d;
    logic         last_q, last_d;
    logic [255:0] dig_q, dig_d;
`ifdef SHA256_DOUBLE_EN
    logic         pass_q, pass_d;
`endif

    work_t        s_nxt;
    work_t        h_sum;
    logic [31:0]  w_nxt [0:15];

    // Round chain: each stage takes the previous stage's working variables.
    for (genvar gi = 0; gi < U; gi++) begin : g_rnd
        work_t si;
        work_t so;
        if (gi == 0) begin : g_src
            assign si = s_q;
        end else begin : g_src
            assign si = g_rnd[gi-1].so;
        end
        sha256_round u_round (
            .s_i (si),
            .k_i (K[rnd_q + 6'(gi)]),
            .w_i (w_q[gi]),
            .s_o (so)
        );
    end
    assign s_nxt = g_rnd[U-1].so;
    assign h_sum = add_words(h_q, s_q);

    // New schedule words may depend on words produced earlier in the same cycle.
    always_comb begin : p_sched
        logic [31:0] ext [0:15+U];
        for (int i = 0; i < 16; i++) ext[i] = w_q[i];
        for (int j = 0; j < U; j++) begin
            ext[16+j] = sml_s1(ext[14+j]) + ext[9+j] + sml_s0(ext[1+j]) + ext[j];
        end
        for (int i = 0; i < 16; i++) w_nxt[i] = ext[i+U];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.blk_valid) state_d = ST_ROUND;
            ST_ROUND: if (rnd_q == RND_LAST) state_d = ST_FINAL;
`ifdef SHA256_DOUBLE_EN
            ST_FINAL: state_d = !last_q ? ST_IDLE : (!pass_q ? ST_ROUND : ST_OUT);
`else
            ST_FINAL: state_d = last_q ? ST_OUT : ST_IDLE;
`endif
            ST_OUT:   if (bus.dig_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.blk_ready = (state_q == ST_IDLE);
        bus.dig_valid = (state_q == ST_OUT);
        bus.busy      = (state_q != ST_IDLE);
        bus.dig       = dig_q;
    end

    always_comb begin
        h_d    = h_q;
        s_d    = s_q;
        w_d    = w_q;
        rnd_d  = rnd_q;
        last_d = last_q;
        dig_d  = dig_q;
`ifdef SHA256_DOUBLE_EN
        pass_d = pass_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.blk_valid) begin
                    for (int i = 0; i < 16; i++) w_d[i] = bus.blk_data[511-32*i -: 32];
                    if (bus.blk_first) begin
                        s_d = IV;
                        h_d = IV;
                    end else begin
                        s_d = h_q;
                    end
                    last_d = bus.blk_last;
                    rnd_d  = '0;
                end
            end
            ST_ROUND: begin
                s_d   = s_nxt;
                w_d   = w_nxt;
                rnd_d = rnd_q + 6'(U);
            end
            ST_FINAL: begin
                h_d = h_sum;
`ifdef SHA256_DOUBLE_EN
                if (last_q && !pass_q) begin
                    // Second pass hashes the 256-bit first digest as a single padded block.
                    for (int i = 0; i < 8; i++) w_d[i] = h_sum[255-32*i -: 32];
                    w_d[8] = 32'h80000000;
                    for (int i = 9; i < 15; i++) w_d[i] = 32'h0;
                    w_d[15] = 32'h00000100;
                    s_d    = IV;
                    h_d    = IV;
                    rnd_d  = '0;
                    pass_d = 1'b1;
                end else if (last_q) begin
                    dig_d  = h_sum;
                    pass_d = 1'b0;
                end
`else
                if (last_q) dig_d = h_sum;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q    <= IV;
            s_q    <= '0;
            for (int i = 0; i < 16; i++) w_q[i] <= '0;
            rnd_q  <= '0;
            last_q <= 1'b0;
            dig_q  <= '0;
`ifdef SHA256_DOUBLE_EN
            pass_q <= 1'b0;
`endif
        end else begin
            h_q    <= h_d;
            s_q    <= s_d;
            w_q    <= w_d;
            rnd_q  <= rnd_d;
            last_q <= last_d;
            dig_q  <= dig_d;
`ifdef SHA256_DOUBLE_EN
            pass_q <= pass_d;
`endif
        end
    end
endmodule
